count_sequencer: RTL and testbench



---
 rtl/count_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_count_sequencer.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_sequencer.sv
// -----------------------------------------------------------------------------
// count_sequencer
//
// Programmable tick scheduler and sequence controller for the lab counter
// datapath. A prescaler divides the system clock into a one-cycle clock-enable
// (tick) every div+1 cycles, and each tick steps an internal counter through
// 0..limit (or limit..0 when down-counting is built in), in one-shot or
// continuous mode, under start/pause/abort control.
//
// Optional feature macro: COUNT_SEQ_DOWN_EN
//   defined   -> the dir input exists; dir=1 at start counts limit..0.
//   undefined -> no dir input, up-counting only, no down-count logic.
//
// Ports:
//   clk        in   system clock, all state updates on the rising edge
//   rst        in   asynchronous active-high reset
//   start      in   level; begins a run from IDLE, resumes from PAUSE
//   stop       in   level; pauses from RUN, aborts from PAUSE (wins over start)
//   cont       in   continuous mode, captured at start from IDLE
//   div        in   [DIV_W-1:0] tick period minus one, captured at start
//   limit      in   [CNT_W-1:0] terminal count, captured at start
//   dir        in   1 = count down (only with COUNT_SEQ_DOWN_EN)
//   tick       out  one-cycle pulse in the cycle the count updates
//   count      out  [CNT_W-1:0] current count
//   busy       out  high in RUN and PAUSE
//   done       out  one-cycle pulse on the terminal tick
//   dbg_state  out  [1:0] FSM state (0 IDLE, 1 RUN, 2 PAUSE) for observation
//
// Control protocol: start and stop are plain levels sampled on every rising
// edge; there is no handshake. A one-cycle stop pulse pauses a run, a second
// stop while paused aborts it, so a stop held for two edges aborts outright.
// All outputs are driven straight from registers.
// -----------------------------------------------------------------------------
module count_sequencer #(
   parameter int DIV_W = 16,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             cont,
   input  logic [DIV_W-1:0] div,
   input  logic [CNT_W-1:0] limit,
`ifdef COUNT_SEQ_DOWN_EN
   input  logic             dir,
`endif
   output logic             tick,
   output logic [CNT_W-1:0] count,
   output logic             busy,
   output logic             done,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } state_t;

   state_t           state_q;
   logic [DIV_W-1:0] presc_q;
   logic [DIV_W-1:0] div_q;
   logic [CNT_W-1:0] limit_q;
   logic [CNT_W-1:0] count_q;
   logic             cont_q;
   logic             tick_q;
   logic             done_q;
   logic             busy_q;

   // Direction-dependent values: where the count ends, what it reloads to,
   // its next value on a non-terminal tick, and the value loaded at start
   // (taken from the live inputs, since it is used in the capturing cycle).
   logic [CNT_W-1:0] cnt_end;
   logic [CNT_W-1:0] cnt_reload;
   logic [CNT_W-1:0] cnt_step_d;
   logic [CNT_W-1:0] cnt_load_d;
   logic             tick_edge;
   logic             at_end;

`ifdef COUNT_SEQ_DOWN_EN
   logic dir_q;

   assign cnt_end    = dir_q ? '0 : limit_q;
   assign cnt_reload = dir_q ? limit_q : '0;
   assign cnt_step_d = dir_q ? (count_q - 1'b1) : (count_q + 1'b1);
   assign cnt_load_d = dir ? limit : '0;
`else
   assign cnt_end    = limit_q;
   assign cnt_reload = '0;
   assign cnt_step_d = count_q + 1'b1;
   assign cnt_load_d = '0;
`endif

   // The prescaler counts 0..div_q; the edge at which it equals div_q is the
   // tick edge, so the tick period is div_q+1 clocks.
   assign tick_edge = (presc_q == div_q);
   // Terminal tick: the count already sits at its end value when it fires.
   assign at_end    = (count_q == cnt_end);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         presc_q <= '0;
         div_q   <= '0;
         limit_q <= '0;
         count_q <= '0;
         cont_q  <= 1'b0;
         tick_q  <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
`ifdef COUNT_SEQ_DOWN_EN
         dir_q   <= 1'b0;
`endif
      end else begin
         // tick and done are single-cycle pulses unless re-raised below.
         tick_q <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               // stop is ignored here, so start alone decides.
               if (start) begin
                  div_q   <= div;
                  limit_q <= limit;
                  cont_q  <= cont;
`ifdef COUNT_SEQ_DOWN_EN
                  dir_q   <= dir;
`endif
                  presc_q <= '0;
                  count_q <= cnt_load_d;
                  busy_q  <= 1'b1;
                  state_q <= ST_RUN;
               end
            end

            ST_RUN: begin
               if (tick_edge) begin
                  // A tick falling on the same edge as stop still takes
                  // effect; the pause applies from the following cycle.
                  presc_q <= '0;
                  tick_q  <= 1'b1;
                  if (at_end) begin
                     done_q <= 1'b1;
                     if (cont_q) begin
                        count_q <= cnt_reload;
                        if (stop) begin
                           state_q <= ST_PAUSE;
                        end
                     end else begin
                        // One-shot run is over: count holds the end value.
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                     end
                  end else begin
                     count_q <= cnt_step_d;
                     if (stop) begin
                        state_q <= ST_PAUSE;
                     end
                  end
               end else if (stop) begin
                  // Freeze the prescaler where it is so the resumed run
                  // finishes the interrupted tick period.
                  state_q <= ST_PAUSE;
               end else begin
                  presc_q <= presc_q + 1'b1;
               end
            end

            ST_PAUSE: begin
               if (stop) begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end else if (start) begin
                  state_q <= ST_RUN;
               end
            end

            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign tick      = tick_q;
   assign done      = done_q;
   assign busy      = busy_q;
   assign count     = count_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_count_sequencer.sv
// -----------------------------------------------------------------------------
// tb_count_sequencer
//
// Directed and randomized stimulus for count_sequencer. A reference model
// expressed as "cycles remaining until the next tick" plus an integer count
// predicts tick/count/busy/done every cycle; predicted tick counts also go
// through an expected queue that is drained as the DUT ticks.
// -----------------------------------------------------------------------------
module tb_count_sequencer;

   localparam int         DIV_W   = 16;
   localparam int         CNT_W   = 3;
   localparam logic [1:0] ST_IDLE = 2'd0;

   // ---------------------------------------------------------------- clock/reset
   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             stop;
   logic             cont;
   logic [DIV_W-1:0] div;
   logic [CNT_W-1:0] limit;
   logic             dir;
   logic             tick;
   logic [CNT_W-1:0] count;
   logic             busy;
   logic             done;
   logic [1:0]       dbg_state;

   always #5 clk = ~clk;

   count_sequencer #(
      .DIV_W(DIV_W),
      .CNT_W(CNT_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .stop     (stop),
      .cont     (cont),
      .div      (div),
      .limit    (limit),
`ifdef COUNT_SEQ_DOWN_EN
      .dir      (dir),
`endif
      .tick     (tick),
      .count    (count),
      .busy     (busy),
      .done     (done),
      .dbg_state(dbg_state)
   );

   // ---------------------------------------------------------------- scoreboard
   int               n_assert;
   int               n_fail;
   logic [CNT_W-1:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------------------------------------------------------- reference model
   // A run is either inactive, active, or active-and-paused. m_rem counts the
   // clocks left until the next tick; a run edge consumes one, pausing does not.
   bit m_active, m_paused, m_cont, m_down, m_tick, m_done;
   int m_rem, m_count, m_div, m_lim;

   function automatic int end_val();
      return m_down ? 0 : m_lim;
   endfunction

   function automatic int first_val();
      return m_down ? m_lim : 0;
   endfunction

   task automatic model_reset();
      m_active = 0;
      m_paused = 0;
      m_tick   = 0;
      m_done   = 0;
      m_count  = 0;
      m_rem    = 1;
      exp_q.delete();
   endtask

   task automatic model_step();
      m_tick = 0;
      m_done = 0;
      if (rst) begin
         model_reset();
         return;
      end
      if (!m_active) begin
         if (start) begin
            m_active = 1;
            m_paused = 0;
            m_div    = int'(div);
            m_lim    = int'(limit);
            m_cont   = cont;
`ifdef COUNT_SEQ_DOWN_EN
            m_down   = dir;
`else
            m_down   = 0;
`endif
            m_rem    = m_div + 1;
            m_count  = first_val();
         end
      end else if (m_paused) begin
         if (stop) m_active = 0;
         else if (start) m_paused = 0;
      end else if (stop && m_rem != 1) begin
         m_paused = 1;
      end else begin
         m_rem--;
         if (m_rem == 0) begin
            m_rem  = m_div + 1;
            m_tick = 1;
            if (m_count == end_val()) begin
               m_done = 1;
               if (m_cont) m_count = first_val();
               else m_active = 0;
            end else begin
               m_count += m_down ? -1 : 1;
            end
            exp_q.push_back(CNT_W'(m_count));
            if (stop && m_active) m_paused = 1;
         end
      end
   endtask

   task automatic check_outputs();
      chk("tick", 32'(tick), 32'(m_tick));
      chk("count", 32'(count), 32'(m_count));
      chk("busy", 32'(busy), 32'(m_active));
      chk("done", 32'(done), 32'(m_done));
      if (tick === 1'b1) begin
         if (exp_q.size() > 0) chk("sb_tick_count", 32'(count), 32'(exp_q.pop_front()));
         else chk("sb_extra_tick", 32'(tick), 32'd0);
      end
   endtask

   // ---------------------------------------------------------------- driver tasks
   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      check_outputs();
   endtask

   task automatic configure(input int d, input int l, input int c);
      div   = DIV_W'(d);
      limit = CNT_W'(l);
      cont  = (c != 0);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cycle();
      start = 1'b0;
   endtask

   task automatic pulse_stop_twice();
      stop = 1'b1;
      cycle();
      cycle();
      stop = 1'b0;
   endtask

   task automatic run_until_count(input int target, input int budget);
      int n;
      n = 0;
      while (count !== CNT_W'(target) && n < budget) begin
         cycle();
         n++;
      end
      chk("reach_count", 32'(count), 32'(target));
   endtask

   task automatic run_until_idle(input int budget);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < budget) begin
         cycle();
         n++;
      end
      chk("reach_idle", 32'(busy), 32'd0);
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      int exp_up[4];
      int ticks, first, dn, dones, n;

      exp_up   = '{1, 2, 3, 3};
      n_assert = 0;
      n_fail   = 0;
      rst      = 1'b1;
      start    = 1'b0;
      stop     = 1'b0;
      dir      = 1'b0;
      configure(0, 0, 0);
      model_reset();

      // Reset state.
      #2;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_tick", 32'(tick), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
      cycle();
      cycle();
      rst = 1'b0;
      cycle();

      // div=0, limit=3, one-shot: four consecutive ticks, count 1,2,3,3.
      configure(0, 3, 0);
      pulse_start();
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("A_tick", 32'(tick), 32'd1);
         chk("A_count", 32'(count), 32'(exp_up[i]));
      end
      chk("A_done_last", 32'(done), 32'd1);
      chk("A_busy_last", 32'(busy), 32'd0);
      chk("A_state", 32'(dbg_state), 32'(ST_IDLE));
      cycle();
      cycle();

      // div=4, limit=7, one-shot: first tick 5 cycles in, 8 ticks, done at 40.
      configure(4, 7, 0);
      pulse_start();
      ticks = 0;
      first = 0;
      dn    = 0;
      for (int i = 1; i <= 100; i++) begin
         cycle();
         if (tick === 1'b1) begin
            ticks++;
            if (first == 0) first = i;
         end
         if (done === 1'b1) begin
            dn = i;
            break;
         end
      end
      chk("B_first_tick_latency", 32'(first), 32'd5);
      chk("B_done_latency", 32'(dn), 32'd40);
      chk("B_tick_total", 32'(ticks), 32'd8);

      // Continuous, div=0, limit=7, with a redundant start mid-run.
      configure(0, 7, 1);
      pulse_start();
      dones = 0;
      for (int i = 1; i <= 30; i++) begin
         start = (i == 10);
         cycle();
         chk("C_busy", 32'(busy), 32'd1);
         if (done === 1'b1) dones++;
      end
      start = 1'b0;
      chk("C_done_pulses", 32'(dones), 32'd3);
      pulse_stop_twice();
      chk("C_abort_busy", 32'(busy), 32'd0);

      // Pause at count=2 with div=2, hold, resume.
      configure(2, 7, 0);
      pulse_start();
      run_until_count(2, 50);
      stop = 1'b1;
      cycle();
      stop = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cycle();
         chk("P_tick", 32'(tick), 32'd0);
         chk("P_count", 32'(count), 32'd2);
         chk("P_busy", 32'(busy), 32'd1);
      end
      pulse_start();
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         cycle();
         if (tick === 1'b1) begin
            n = i;
            break;
         end
      end
      chk("P_resume_latency", 32'(n), 32'd3);
      run_until_idle(100);
      chk("P_final_count", 32'(count), 32'd7);

      // Pause again, then start+stop together aborts with count held at 2.
      pulse_start();
      run_until_count(2, 50);
      stop = 1'b1;
      cycle();
      start = 1'b1;
      cycle();
      start = 1'b0;
      stop  = 1'b0;
      chk("Q_abort_count", 32'(count), 32'd2);
      chk("Q_abort_busy", 32'(busy), 32'd0);
      chk("Q_abort_state", 32'(dbg_state), 32'(ST_IDLE));
      cycle();

      // limit=0, continuous: every tick terminal, count stays 0.
      configure(1, 0, 1);
      pulse_start();
      dones = 0;
      for (int i = 0; i < 12; i++) begin
         cycle();
         if (done === 1'b1) dones++;
      end
      chk("L0_done_pulses", 32'(dones), 32'd6);
      pulse_stop_twice();

      // Asynchronous reset in the middle of a run at count=5.
      configure(0, 7, 0);
      pulse_start();
      run_until_count(5, 20);
      #3;
      rst = 1'b1;
      model_reset();
      #1;
      chk("AR_count", 32'(count), 32'd0);
      chk("AR_busy", 32'(busy), 32'd0);
      chk("AR_tick", 32'(tick), 32'd0);
      chk("AR_done", 32'(done), 32'd0);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 5; i++) cycle();
      chk("AR_idle_state", 32'(dbg_state), 32'(ST_IDLE));

`ifdef COUNT_SEQ_DOWN_EN
      // Down count from 5: 4,3,2,1,0 then terminal tick at 0.
      configure(0, 5, 0);
      dir = 1'b1;
      pulse_start();
      dir = 1'b0;
      chk("D_load", 32'(count), 32'd5);
      for (int i = 0; i < 6; i++) begin
         cycle();
         chk("D_tick", 32'(tick), 32'd1);
         chk("D_count", 32'(i < 5 ? 4 - i : 0), 32'(count));
      end
      chk("D_done", 32'(done), 32'd1);
      chk("D_busy", 32'(busy), 32'd0);
      cycle();
`endif

      // Randomized control and configuration, every cycle.
      for (int i = 0; i < 600; i++) begin
         configure($urandom_range(0, 4), $urandom_range(0, 7), $urandom_range(0, 1));
         dir   = 1'($urandom_range(0, 1));
         start = ($urandom_range(0, 5) == 0);
         stop  = ($urandom_range(0, 11) == 0);
         cycle();
      end
      start = 1'b0;
      pulse_stop_twice();
      chk("R_end_busy", 32'(busy), 32'd0);

      chk("sb_drain", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
